// File: rtl/gate_pkg.sv
// Shared definitions for the gate-op scheduler: opcode encoding and FSM states.
// Imported by the logic unit and the scheduler top.
package gate_pkg;

    localparam int OPW = 3;

    localparam logic [OPW-1:0] OP_AND  = 3'd0;
    localparam logic [OPW-1:0] OP_OR   = 3'd1;
    localparam logic [OPW-1:0] OP_XOR  = 3'd2;
    localparam logic [OPW-1:0] OP_NAND = 3'd3;
    localparam logic [OPW-1:0] OP_NOR  = 3'd4;
    localparam logic [OPW-1:0] OP_NOT  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/gate_alu.sv
// Combinational bitwise logic unit; opcodes 6 and 7 return zero and flag an error.
// Kept free of scheduler state so lab exercises can instantiate it on its own.
module gate_alu
    import gate_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [OPW-1:0]   op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] y,
    output logic             err
);

    always_comb begin
        y   = '0;
        err = 1'b0;
        case (op)
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            OP_NAND: y = ~(a & b);
            OP_NOR:  y = ~(a | b);
            OP_NOT:  y = ~a;
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/gate_op_scheduler.sv
// Round-robin sharing of one gate_alu among NREQ requesters, with a
// three-state IDLE/EXEC/RESP sequencer and a registered valid/ready response.
module gate_op_scheduler
    import gate_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [3*NREQ-1:0]     req_op,
    input  logic [WIDTH*NREQ-1:0] req_a,
    input  logic [WIDTH*NREQ-1:0] req_b,
    output logic [NREQ-1:0]       req_ready,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [WIDTH-1:0]      rsp_y,
    output logic                  rsp_err,
    output logic [7:0]            done_count
);

    state_t           state_reg;
    logic [IDW-1:0]   rr_ptr_reg;
    logic             rsp_valid_reg;
    logic [WIDTH-1:0] rsp_y_reg;
    logic [IDW-1:0]   rsp_id_reg;
    logic             rsp_err_reg;
    logic [7:0]       done_count_reg;

    logic [OPW-1:0]   op_reg;
    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;

    logic [OPW-1:0]   op_arr [NREQ];
    logic [WIDTH-1:0] a_arr  [NREQ];
    logic [WIDTH-1:0] b_arr  [NREQ];

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_unpack
            assign op_arr[gi] = req_op[OPW*gi +: OPW];
            assign a_arr[gi]  = req_a[WIDTH*gi +: WIDTH];
            assign b_arr[gi]  = req_b[WIDTH*gi +: WIDTH];
        end
    endgenerate

    // Scan from the farthest offset down so the nearest valid requester at or
    // after rr_ptr overwrites earlier candidates. NREQ is a power of two, so
    // the IDW-bit sum wraps around naturally.
    logic [IDW-1:0] scan_idx;
    logic [IDW-1:0] grant_id;
    logic           grant_any;

    always_comb begin
        scan_idx  = '0;
        grant_id  = '0;
        grant_any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            scan_idx = rr_ptr_reg + IDW'(k);
            if (req_valid[scan_idx]) begin
                grant_id  = scan_idx;
                grant_any = 1'b1;
            end
        end
    end

    logic transfer;
    assign transfer  = (state_reg == IDLE) && !reset && grant_any;
    assign req_ready = transfer ? (NREQ'(1) << grant_id) : '0;

    logic [WIDTH-1:0] alu_y;
    logic             alu_err;

    gate_alu #(
        .WIDTH(WIDTH)
    ) u_alu (
        .op (op_reg),
        .a  (a_reg),
        .b  (b_reg),
        .y  (alu_y),
        .err(alu_err)
    );

    // Operand latches carry no reset: they are only consumed after a transfer.
    always_ff @(posedge clk) begin
        if (transfer) begin
            op_reg <= op_arr[grant_id];
            a_reg  <= a_arr[grant_id];
            b_reg  <= b_arr[grant_id];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= IDLE;
            rr_ptr_reg     <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_y_reg      <= '0;
            rsp_id_reg     <= '0;
            rsp_err_reg    <= 1'b0;
            done_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (transfer) begin
                        rsp_id_reg <= grant_id;
                        state_reg  <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_y_reg     <= alu_y;
                    rsp_err_reg   <= alu_err;
                    rsp_valid_reg <= 1'b1;
                    state_reg     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_reg  <= 1'b0;
                        done_count_reg <= done_count_reg + 8'd1;
                        rr_ptr_reg     <= rsp_id_reg + IDW'(1);
                        state_reg      <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_reg;
    assign rsp_y      = rsp_y_reg;
    assign rsp_id     = rsp_id_reg;
    assign rsp_err    = rsp_err_reg;
    assign done_count = done_count_reg;

endmodule

// File: tb/tb_gate_op_scheduler.sv
// Self-checking bench for gate_op_scheduler: directed scenarios plus randomized
// traffic compared against a per-requester queue model of the arbitration rules.
module tb_gate_op_scheduler;

    localparam int NREQ  = 4;
    localparam int WIDTH = 4;
    localparam int IDW   = 2;

    logic                  clk;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [3*NREQ-1:0]     req_op;
    logic [WIDTH*NREQ-1:0] req_a;
    logic [WIDTH*NREQ-1:0] req_b;
    logic [NREQ-1:0]       req_ready;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_y;
    logic                  rsp_err;
    logic [7:0]            done_count;

    gate_op_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH), .IDW(IDW)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_y     (rsp_y),
        .rsp_err   (rsp_err),
        .done_count(done_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Pending request presented by each requester.
    logic             p_valid [NREQ];
    logic [2:0]       p_op    [NREQ];
    logic [WIDTH-1:0] p_a     [NREQ];
    logic [WIDTH-1:0] p_b     [NREQ];

    int m_rr   = 0;
    int m_done = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [WIDTH-1:0] ref_y(input logic [2:0] op, input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a ^ b;
            3'd3:    return ~(a & b);
            3'd4:    return ~(a | b);
            3'd5:    return ~a;
            default: return '0;
        endcase
    endfunction

    function automatic int exp_winner();
        for (int k = 0; k < NREQ; k++) begin
            int idx;
            idx = (m_rr + k) % NREQ;
            if (p_valid[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req_valid[i]           = p_valid[i];
            req_op[3*i +: 3]       = p_op[i];
            req_a[WIDTH*i +: WIDTH] = p_a[i];
            req_b[WIDTH*i +: WIDTH] = p_b[i];
        end
    endtask

    task automatic clear_reqs();
        for (int i = 0; i < NREQ; i++) begin
            p_valid[i] = 1'b0;
            p_op[i]    = 3'd0;
            p_a[i]     = '0;
            p_b[i]     = '0;
        end
    endtask

    task automatic set_req(input int i, input logic [2:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b);
        p_valid[i] = 1'b1;
        p_op[i]    = op;
        p_a[i]     = a;
        p_b[i]     = b;
    endtask

    task automatic reset_dut();
        @(negedge clk);
        reset = 1'b1;
        clear_reqs();
        drive();
        rsp_ready = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        m_rr   = 0;
        m_done = 0;
    endtask

    // One full transaction: grant in the first cycle, EXEC, then RESP held for
    // 'stall' cycles with rsp_ready low before it is accepted.
    task automatic run_txn(input int stall, output int won, output logic [WIDTH-1:0] first_y);
        int               ew;
        logic [NREQ-1:0]  eg;
        logic [WIDTH-1:0] ey;
        logic             ee;
        ew      = exp_winner();
        won     = -1;
        first_y = '0;
        if (ew < 0) begin
            check("no_pending_request", 32'(1), 32'(0));
            return;
        end
        eg     = '0;
        eg[ew] = 1'b1;
        ey     = ref_y(p_op[ew], p_a[ew], p_b[ew]);
        ee     = (p_op[ew] >= 3'd6);

        @(negedge clk);
        drive();
        rsp_ready = 1'($urandom_range(0, 1));
        #1;
        check("idle_rsp_valid", 32'(rsp_valid), 32'(0));
        check("idle_done_count", 32'(done_count), 32'(m_done));
        check("grant", 32'(req_ready), 32'(eg));
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) won = i;
        p_valid[ew] = 1'b0;

        @(negedge clk);
        drive();
        rsp_ready = 1'($urandom_range(0, 1));
        #1;
        check("exec_rsp_valid", 32'(rsp_valid), 32'(0));
        check("exec_ready", 32'(req_ready), 32'(0));

        for (int s = 0; s <= stall; s++) begin
            @(negedge clk);
            drive();
            rsp_ready = (s == stall);
            #1;
            if (s == 0) first_y = rsp_y;
            check("resp_valid", 32'(rsp_valid), 32'(1));
            check("resp_y", 32'(rsp_y), 32'(ey));
            check("resp_id", 32'(rsp_id), 32'(ew));
            check("resp_err", 32'(rsp_err), 32'(ee));
            check("resp_ready_low", 32'(req_ready), 32'(0));
            check("resp_done_count", 32'(done_count), 32'(m_done));
        end
        $display("txn id=%0d op=%0d a=%b b=%b y=%b err=%0d stall=%0d done=%0d",
                 ew, p_op[ew], p_a[ew], p_b[ew], ey, ee, stall, (m_done + 1) % 256);
        m_done = (m_done + 1) % 256;
        m_rr   = (ew + 1) % NREQ;
    endtask

    initial begin
        int               won;
        logic [WIDTH-1:0] y;
        int               rr_exp [5];
        int               rr2_exp [3];
        logic [WIDTH-1:0] sweep_exp [7];
        logic [NREQ-1:0]  eg;
        int               any;

        rr_exp  = '{0, 1, 2, 3, 0};
        rr2_exp = '{2, 0, 2};
        sweep_exp = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b0011, 4'b0000};

        // Reset with every requester asserting: no grant may appear.
        reset     = 1'b1;
        rsp_ready = 1'b0;
        for (int i = 0; i < NREQ; i++) set_req(i, 3'(i), 4'($urandom), 4'($urandom));
        drive();
        repeat (3) @(negedge clk);
        drive();
        #1;
        check("reset_ready", 32'(req_ready), 32'(0));
        check("reset_rsp_valid", 32'(rsp_valid), 32'(0));
        check("reset_rsp_y", 32'(rsp_y), 32'(0));
        check("reset_rsp_id", 32'(rsp_id), 32'(0));
        check("reset_rsp_err", 32'(rsp_err), 32'(0));
        check("reset_done", 32'(done_count), 32'(0));
        reset_dut();

        // Single request and opcode sweep on requester 0.
        for (int op = 0; op <= 6; op++) begin
            set_req(0, 3'(op), 4'b1100, 4'b1010);
            run_txn(0, won, y);
            check("sweep_id", 32'(won), 32'(0));
            check("sweep_y", 32'(y), 32'(sweep_exp[op]));
        end

        // Round-robin with all four held valid.
        reset_dut();
        for (int i = 0; i < NREQ; i++) set_req(i, 3'($urandom_range(0, 5)), 4'($urandom), 4'($urandom));
        for (int n = 0; n < 5; n++) begin
            run_txn(0, won, y);
            check("rr_order", 32'(won), 32'(rr_exp[n]));
            for (int i = 0; i < NREQ; i++) p_valid[i] = 1'b1;
        end
        clear_reqs();
        set_req(0, 3'd1, 4'($urandom), 4'($urandom));
        set_req(2, 3'd2, 4'($urandom), 4'($urandom));
        for (int n = 0; n < 3; n++) begin
            run_txn(0, won, y);
            check("rr2_order", 32'(won), 32'(rr2_exp[n]));
            p_valid[0] = 1'b1;
            p_valid[2] = 1'b1;
        end

        // Backpressure: five stalled cycles, then the waiting requester is
        // granted in the very next cycle.
        clear_reqs();
        set_req(1, 3'd3, 4'b0110, 4'b0101);
        set_req(3, 3'd4, 4'b0011, 4'b1000);
        run_txn(5, won, y);
        check("bp_first", 32'(won), 32'(3));
        run_txn(0, won, y);
        check("bp_second", 32'(won), 32'(1));

        // Reset while in EXEC: the request is dropped with no response.
        clear_reqs();
        set_req(2, 3'd0, 4'b1111, 4'b1111);
        eg = '0;
        eg[exp_winner()] = 1'b1;
        @(negedge clk);
        drive();
        #1;
        check("abort_grant", 32'(req_ready), 32'(eg));
        clear_reqs();
        @(negedge clk);
        reset = 1'b1;
        drive();
        #1;
        check("abort_reset_ready", 32'(req_ready), 32'(0));
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_rsp_valid", 32'(rsp_valid), 32'(0));
        check("abort_done", 32'(done_count), 32'(0));
        check("abort_ready", 32'(req_ready), 32'(0));
        @(negedge clk);
        #1;
        check("abort_no_rsp", 32'(rsp_valid), 32'(0));
        m_rr   = 0;
        m_done = 0;
        for (int i = 1; i < NREQ; i++) set_req(i, 3'd2, 4'($urandom), 4'($urandom));
        run_txn(0, won, y);
        check("abort_rr_ptr", 32'(won), 32'(1));

        // Randomized traffic: 256 completions from reset must wrap the counter.
        reset_dut();
        clear_reqs();
        for (int n = 0; n < 256; n++) begin
            for (int i = 0; i < NREQ; i++)
                if (!p_valid[i] && $urandom_range(0, 2) != 0)
                    set_req(i, 3'($urandom_range(0, 7)), 4'($urandom), 4'($urandom));
            if ($urandom_range(0, 7) == 0) p_valid[$urandom_range(0, NREQ - 1)] = 1'b0;
            any = 0;
            for (int i = 0; i < NREQ; i++) if (p_valid[i]) any = 1;
            if (any == 0) set_req($urandom_range(0, NREQ - 1), 3'($urandom_range(0, 7)),
                                  4'($urandom), 4'($urandom));
            run_txn($urandom_range(0, 2), won, y);
        end
        clear_reqs();
        @(negedge clk);
        drive();
        #1;
        check("wrap_done", 32'(done_count), 32'(0));
        check("wrap_rsp_valid", 32'(rsp_valid), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gate_op_scheduler.md
Name: gate_op_scheduler

Overview:
- Shares one 4-bit logic unit (AND/OR/XOR/NAND/NOR/NOT) between NREQ requesters.
- A round-robin arbiter accepts one request at a time.
- A three-state FSM sequences the operation and returns a registered result with the winner's id over a valid/ready response channel.
- Sits between several lab-board front-ends (switch/button decoders) and the shared logic-unit datapath.

Parameters:
- NREQ, 4, number of requesters; power of two, 2..8.
- WIDTH, 4, operand/result width in bits.
- IDW, 2, id width; must equal log2(NREQ).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  NREQ  bit i: requester i presents an operation.
- req_op  input  3*NREQ  opcode of requester i at bits [3i+2:3i].
- req_a  input  WIDTH*NREQ  operand a of requester i at bits [WIDTH*i+WIDTH-1:WIDTH*i].
- req_b  input  WIDTH*NREQ  operand b of requester i, same packing as req_a.
- req_ready  output  NREQ  one-hot grant; a transfer happens when req_valid[i] & req_ready[i].
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_id  output  IDW  index of the requester that owns the result.
- rsp_y  output  WIDTH  result.
- rsp_err  output  1  opcode was illegal.
- done_count  output  8  completed-response counter; wraps 255 -> 0.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high (reset).
- Opcodes: 0 AND, 1 OR, 2 XOR, 3 NAND (~(a&b)), 4 NOR (~(a|b)), 5 NOT (~a, b ignored).
  - 6 and 7 are illegal: y = 0, rsp_err = 1.
- States: IDLE, EXEC, RESP.
- Reset values (taken on the rising edge with reset=1; also applies mid-operation):
  - state = IDLE, rr_ptr = 0, rsp_valid = 0, rsp_y = 0, rsp_id = 0, rsp_err = 0, done_count = 0.
  - Any in-flight transaction is discarded with no response.
  - req_ready = 0 during any cycle with reset=1.
- IDLE:
  - req_ready is combinational: the one-hot winner among req_valid, searching upward from rr_ptr with wrap-around (rr_ptr, rr_ptr+1, ..., NREQ-1, 0, ...).
  - req_ready = 0 when no valid is asserted.
  - On a transfer, latch op/a/b/id of the winner and go to EXEC.
- EXEC:
  - Register y/err from the logic unit on the latched operands; go to RESP.
  - req_ready = 0.
- RESP:
  - rsp_valid = 1; rsp_y, rsp_id and rsp_err are held stable until accepted.
  - On rsp_ready=1: done_count += 1, rr_ptr = (id+1) mod NREQ, go to IDLE.
  - If rsp_ready=0, stay in RESP indefinitely.
- Latency and throughput:
  - Transfer in cycle T, rsp_valid first high in cycle T+2.
  - With rsp_ready tied high, one transaction every 3 cycles.
- Requester rules:
  - Requesters hold valid and operands stable until ready.
  - Dropping req_valid before the grant is legal; that requester is simply not selected.
- Fairness: a requester that stays valid is served within NREQ transactions.
- Simultaneous events: reset has priority over everything. A rsp_ready pulse outside RESP is ignored.
- Width: all logic ops are bitwise on WIDTH bits; no carry or extension.

Decomposition:
- Shared package gate_pkg:
  - Opcode constants OP_AND..OP_NOT.
  - Opcode width (3).
  - FSM state encoding (IDLE=0, EXEC=1, RESP=2).
- Sub-module gate_alu: combinational (op, a, b) -> (y, err), WIDTH-parameterised. It is reused standalone in lab exercises.
- The arbiter stays inline in gate_op_scheduler.

Test Plan:
- Single request: reset, then req_valid=0001, op=0, a=4'b1100, b=4'b1010, rsp_ready=1.
  - Expect req_ready=0001 in cycle T.
  - Expect rsp_valid at T+2 with rsp_y=4'b1000, rsp_id=0, rsp_err=0, and done_count=1 afterwards.
- Opcode sweep, a=4'b1100, b=4'b1010, ops 1..5:
  - Expect y = 1110, 0110, 0111, 0001, 0011.
  - op=6: expect y=0000, rsp_err=1.
- Round-robin: req_valid=1111 held, rsp_ready=1.
  - Expect grant order 0,1,2,3,0 and rsp_id matching.
  - With 0101 held from rr_ptr=1, expect order 2,0,2.
- Backpressure: rsp_ready=0 for 5 cycles in RESP.
  - Expect rsp_valid, rsp_y, rsp_id stable, req_ready=0000, done_count unchanged.
  - Raise rsp_ready and expect return to IDLE the next cycle.
- Reset mid-operation: assert reset in EXEC.
  - Expect the next cycle in IDLE with rsp_valid=0, rr_ptr=0, done_count=0, and no response for the aborted request.
- Counter wrap: 256 completed transactions → done_count returns to 0.
